// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: hex decode, per-digit dp/blank, refresh scan, frame-synchronous commit.
// Optional build macro SEG7_LZB_EN enables leading-zero blanking on the committed display value.
module seg7_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int DIV         = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [4*DIGITS-1:0] wr_data,
  input  logic [DIGITS-1:0]   wr_dp,
  input  logic [DIGITS-1:0]   wr_blank,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done,
  output logic                busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Scan state
  logic [DIV_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_frame_done;

  // Host-facing shadow and the committed display copy
  logic [4*DIGITS-1:0] r_sh_data;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_blank;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_disp_data;
  logic [DIGITS-1:0]   r_disp_dp;
  logic [DIGITS-1:0]   r_disp_blank;

  // Output stage, held active-high internally
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_div_wrap;
  logic                w_frame_end;
  logic [DIGITS-1:0]   w_dark;
  logic [3:0]          w_nib;
  logic                w_dp_sel;
  logic                w_dark_sel;
  logic [DIGITS-1:0]   w_an_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_div_wrap  = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_div_wrap && (r_idx == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  // A write landing in the frame-end cycle goes straight to the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data    <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      r_pending    <= 1'b0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      // NOTE: display blank mask resets to all ones so nothing lights before the first commit.
      r_disp_blank <= '1;
    end else begin
      if (wr_en) begin
        r_sh_data  <= wr_data;
        r_sh_dp    <= wr_dp;
        r_sh_blank <= wr_blank;
      end
      if (w_frame_end) begin
        r_pending <= 1'b0;
        if (wr_en) begin
          r_disp_data  <= wr_data;
          r_disp_dp    <= wr_dp;
          r_disp_blank <= wr_blank;
        end else if (r_pending) begin
          r_disp_data  <= r_sh_data;
          r_disp_dp    <= r_sh_dp;
          r_disp_blank <= r_sh_blank;
        end
      end else if (wr_en) begin
        r_pending <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZB_EN
  // A zero is dark when every more-significant digit is zero or blanked; digit 0 always shows.
  always_comb begin : lzb
    logic w_higher_zero;
    w_higher_zero = 1'b1;
    w_dark        = r_disp_blank;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((i != 0) && w_higher_zero && (r_disp_data[4*i +: 4] == 4'h0)) begin
        w_dark[i] = 1'b1;
      end
      w_higher_zero = w_higher_zero &
                      ((r_disp_data[4*i +: 4] == 4'h0) | r_disp_blank[i]);
    end
  end
`else
  assign w_dark = r_disp_blank;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_nib      = 4'h0;
    w_dp_sel   = 1'b0;
    w_dark_sel = 1'b1;
    w_an_next  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib        = r_disp_data[4*i +: 4];
        w_dp_sel     = r_disp_dp[i];
        w_dark_sel   = w_dark[i];
        w_an_next[i] = 1'b1;
      end
    end
  end

  // Blanked digits keep their anode slot so the refresh duty cycle stays uniform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_dp  <= 1'b0;
      r_an  <= '0;
    end else begin
      r_seg <= w_dark_sel ? 7'h00 : hex_to_seg(w_nib);
      r_dp  <= w_dark_sel ? 1'b0 : w_dp_sel;
      r_an  <= w_an_next;
    end
  end

  assign seg        = (SEG_ACT_LOW != 0) ? ~r_seg : r_seg;
  assign dp         = (SEG_ACT_LOW != 0) ? ~r_dp  : r_dp;
  assign an         = (AN_ACT_LOW  != 0) ? ~r_an  : r_an;
  assign frame_done = r_frame_done;
  assign busy       = r_pending;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a DIGITS-wide common-anode/cathode seven-segment bank: hex decode (0-F), per-digit decimal point, per-digit blanking, refresh scan.
- Double-buffered: host writes a shadow register; the shadow register commits to the display only at frame boundaries, so there is no tearing.
- Sits between CPU/MMIO or debug logic and the board's segment/anode pins.

Parameters:
- DIGITS, 8, number of digits scanned (1..16).
- DIV, 50000, clk cycles each digit stays lit (>=1).
- SEG_ACT_LOW, 1, 1 = segment/dp outputs active-low; 0 = active-high.
- AN_ACT_LOW, 1, 1 = anode enables active-low; 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  load shadow register this cycle.
- wr_data  input  4*DIGITS  nibble i = value of digit i (digit 0 = rightmost).
- wr_dp  input  DIGITS  decimal-point enable per digit.
- wr_blank  input  DIGITS  1 = digit i dark.
- seg  output  7  segments, bit0=a ... bit6=g.
- dp  output  1  decimal point of the active digit.
- an  output  DIGITS  one-hot digit enable, after polarity adjustment.
- frame_done  output  1  one-cycle pulse at the end of each full scan.
- busy  output  1  shadow written but not yet committed.

Behaviour:
Reset:
- rst_n low forces all registers to 0: divider, digit index, shadow, display, pending, frame_done.
- During and after reset, outputs are all inactive:
  - seg = 7'h7F and dp = 1 when SEG_ACT_LOW, else 0.
  - an = all 1s when AN_ACT_LOW, else all 0s.
- Reset is asynchronous and may occur mid-scan or mid-commit. The display reverts to blank; no partial commit is kept.

Divider:
- div_cnt counts 0..DIV-1 and wraps.
- When div_cnt == DIV-1, the digit index idx advances, wrapping DIGITS-1 -> 0.
- DIV=1: idx advances every cycle.

Frame end:
- Frame end = the cycle with div_cnt == DIV-1 and idx == DIGITS-1.
- In that cycle, frame_done = 1 on the following clock edge, for exactly 1 cycle.

Write and commit:
- wr_en captures wr_data/wr_dp/wr_blank into the shadow and sets pending (busy=1) on the next edge. A later wr_en overwrites the shadow; last write wins.
- At frame end with pending=1: the shadow copies into the display registers and pending clears.
- wr_en in the frame-end cycle bypasses: the new wr_* values are committed directly and pending stays 0.

Output stage:
- Registered, 1-cycle latency from idx/display to seg/dp/an.
- Active digit: an one-hot at bit idx (polarity-adjusted).
- Blanked digit: seg and dp inactive, but an still asserted, so scan timing is uniform.

Decode, active-high gfedcba:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Inverted when SEG_ACT_LOW.
- The decode is total; no X or default-zero outputs for any nibble.

After reset:
- The first frame shows blank (display registers = 0, blank bits = 0 → shows "0" on every digit).
- Correction, fixed requirement: reset sets the display blank register to all 1s, so every digit is dark until the first commit.

Width rules:
- idx width = clog2(DIGITS), minimum 1.
- div_cnt width = clog2(DIV), minimum 1.
- No overflow past DIV-1 or DIGITS-1.

Optional Feature:
SEG7_LZB_EN
- Defined: leading-zero blanking. A digit i whose committed nibble is 0 is forced dark if every digit j>i is either 0 or blanked.
  - Digit 0 is never auto-blanked, so a value of 0 displays a single "0".
  - Explicit wr_blank bits still apply.
  - Evaluated combinationally on the display registers; adds no latency.
- Undefined: zeros are always displayed unless wr_blank is set.

Test Plan (DIGITS=4, DIV=3, SEG_ACT_LOW=1, AN_ACT_LOW=1 unless stated):
1. Reset behaviour:
   - Stimulus: assert rst_n low mid-scan, then release.
   - Required: seg=7F, dp=1, an=4'hF immediately.
   - After release: an cycles E,D,B,7, holding each value 3 cycles.
   - Required: frame_done pulses every 12 cycles.
2. Write and commit:
   - Stimulus: wr_en with wr_data=16'h12AF, wr_dp=0, wr_blank=0 early in a frame.
   - Required: busy=1 until frame end.
   - Next frame: digit0 seg=~71=0E, digit1 ~77=08, digit2 ~5B=24, digit3 ~06=79.
   - Required: busy returns to 0.
3. Last write wins:
   - Stimulus: two wr_en in one frame, values 16'h1111 then 16'h2222.
   - Required: only 2222 is displayed; no frame shows 1111.
4. Bypass commit:
   - Stimulus: wr_en exactly in the frame-end cycle with 16'h0005.
   - Required: 16'h0005 is displayed the very next frame; busy never rises.
5. Blanking and decimal point:
   - Stimulus: wr_blank=4'b0100, wr_dp=4'b0001.
   - Required: digit2 seg=7F, dp=1 while an=B.
   - Required: digit0 dp=0 (lit) while an=E.
6. SEG7_LZB_EN defined:
   - Stimulus: value 16'h0070.
   - Required: digits 3 and 2 dark; digit1 shows 7, digit0 shows 0.
   - Stimulus: value 16'h0000.
   - Required: only digit0 shows 0.
